// File: rtl/brent_kung_sub32_pipe_pkg.sv
// Shared Brent-Kung prefix types and cell functions, common to the adder library.
package bk_pkg;

  localparam int BK_WIDTH = 32;
  localparam int LOG2W    = $clog2(BK_WIDTH);

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  typedef gp_t [BK_WIDTH-1:0] gp_vec_t;

  function automatic gp_t bk_black(input gp_t gp_hi, input gp_t gp_lo);
    gp_t r;
    r.g = gp_hi.g | (gp_hi.p & gp_lo.g);
    r.p = gp_hi.p & gp_lo.p;
    return r;
  endfunction

  // Gray cell: the low side is already a complete prefix, so only its generate matters.
  function automatic gp_t bk_gray(input gp_t gp_hi, input logic g_lo);
    gp_t r;
    r.g = gp_hi.g | (gp_hi.p & g_lo);
    r.p = gp_hi.p;
    return r;
  endfunction

endpackage

// File: rtl/brent_kung_sub32_pipe_stage.sv
// One pipeline stage: valid bit plus data register, advancing when empty or drained downstream.
module bk_pipe_stage #(
  parameter int DW = 8
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          valid_i,
  input  logic          adv_next_i,
  input  logic [DW-1:0] data_i,
  output logic          adv_o,
  output logic          valid_o,
  output logic [DW-1:0] data_o
);

  logic          valid_q;
  logic [DW-1:0] data_q;

  assign adv_o   = ~valid_q | adv_next_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (adv_o) begin
      valid_q <= valid_i;
      if (valid_i) begin
        data_q <= data_i;
      end
    end
  end

endmodule

// File: rtl/brent_kung_sub32_pipe.sv
// Three-stage Brent-Kung subtractor D = A - B - Bin with valid/ready handshake.
// Defining SUB_FLAGS_EN adds registered Z/N/V flag outputs.
module brent_kung_sub32_pipe
  import bk_pkg::*;
#(
  parameter int WIDTH = BK_WIDTH
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] D,
  output logic             Bout
`ifdef SUB_FLAGS_EN
  ,
  output logic             Z,
  output logic             N,
  output logic             V
`endif
);

  localparam int LW = $clog2(WIDTH);

  typedef struct packed {
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic             c0;
`ifdef SUB_FLAGS_EN
    logic             aMsb;
    logic             bMsb;
`endif
  } s1_t;

  typedef struct packed {
    gp_t [WIDTH-1:0]  gp;
    logic [WIDTH-1:0] p;
    logic             c0;
`ifdef SUB_FLAGS_EN
    logic             aMsb;
    logic             bMsb;
`endif
  } s2_t;

  typedef struct packed {
    logic [WIDTH-1:0] d;
    logic             bout;
`ifdef SUB_FLAGS_EN
    logic             z;
    logic             n;
    logic             v;
`endif
  } s3_t;

  s1_t  s1_d, s1_q;
  s2_t  s2_d, s2_q;
  s3_t  s3_d, s3_q;
  logic adv1, adv2, adv3;
  logic v1, v2, v3;

  // Subtraction as A + ~B + ~Bin; the carry-in is folded into bit 0's generate.
  always_comb begin
    s1_d      = '0;
    s1_d.c0   = ~Bin;
    s1_d.p    = A ^ ~B;
    s1_d.g    = A & ~B;
    s1_d.g[0] = (A[0] & ~B[0]) | ((A[0] ^ ~B[0]) & ~Bin);
`ifdef SUB_FLAGS_EN
    s1_d.aMsb = A[WIDTH-1];
    s1_d.bMsb = B[WIDTH-1];
`endif
  end

  // Up-sweep: after level l, every index i with (i+1) divisible by 2^(l+1) spans 2^(l+1) bits.
  always_comb begin
    gp_t [WIDTH-1:0] up;
    up   = '0;
    s2_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      up[i].g = s1_q.g[i];
      up[i].p = s1_q.p[i];
    end
    for (int l = 0; l < LW; l++) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (((i + 1) % (1 << (l + 1))) == 0) begin
          up[i] = bk_black(up[i], up[i - (1 << l)]);
        end
      end
    end
    s2_d.gp = up;
    s2_d.p  = s1_q.p;
    s2_d.c0 = s1_q.c0;
`ifdef SUB_FLAGS_EN
    s2_d.aMsb = s1_q.aMsb;
    s2_d.bMsb = s1_q.bMsb;
`endif
  end

  // Down-sweep fills the remaining prefixes with gray cells, then the sum XOR.
  always_comb begin
    gp_t [WIDTH-1:0]  dn;
    logic [WIDTH:0]   carry;
    dn   = s2_q.gp;
    s3_d = '0;
    for (int l = LW - 2; l >= 0; l--) begin
      for (int i = 0; i < WIDTH; i++) begin
        if ((i >= 3 * (1 << l) - 1) && (((i + 1) % (1 << (l + 1))) == (1 << l))) begin
          dn[i] = bk_gray(dn[i], dn[i - (1 << l)].g);
        end
      end
    end
    carry[0] = s2_q.c0;
    for (int i = 0; i < WIDTH; i++) begin
      carry[i+1] = dn[i].g;
    end
    s3_d.d    = s2_q.p ^ carry[WIDTH-1:0];
    s3_d.bout = ~carry[WIDTH];
`ifdef SUB_FLAGS_EN
    s3_d.z = (s3_d.d == '0);
    s3_d.n = s3_d.d[WIDTH-1];
    s3_d.v = (s2_q.aMsb ^ s2_q.bMsb) & (s3_d.d[WIDTH-1] ^ s2_q.aMsb);
`endif
  end

  bk_pipe_stage #(.DW($bits(s1_t))) u_s1 (
    .Clk        (Clk),
    .Rst        (Rst),
    .valid_i    (InValid),
    .adv_next_i (adv2),
    .data_i     (s1_d),
    .adv_o      (adv1),
    .valid_o    (v1),
    .data_o     (s1_q)
  );

  bk_pipe_stage #(.DW($bits(s2_t))) u_s2 (
    .Clk        (Clk),
    .Rst        (Rst),
    .valid_i    (v1),
    .adv_next_i (adv3),
    .data_i     (s2_d),
    .adv_o      (adv2),
    .valid_o    (v2),
    .data_o     (s2_q)
  );

  bk_pipe_stage #(.DW($bits(s3_t))) u_s3 (
    .Clk        (Clk),
    .Rst        (Rst),
    .valid_i    (v2),
    .adv_next_i (OutReady),
    .data_i     (s3_d),
    .adv_o      (adv3),
    .valid_o    (v3),
    .data_o     (s3_q)
  );

  assign InReady  = adv1;
  assign OutValid = v3;
  assign D        = s3_q.d;
  assign Bout     = s3_q.bout;
`ifdef SUB_FLAGS_EN
  assign Z = s3_q.z;
  assign N = s3_q.n;
  assign V = s3_q.v;
`endif

endmodule

// File: tb/tb_brent_kung_sub32_pipe.sv
// Directed and randomised checks of the pipelined Brent-Kung subtractor.
// Flag checks are compiled in when SUB_FLAGS_EN is defined.
module tb_brent_kung_sub32_pipe;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        InValid;
  logic        InReady;
  logic [31:0] A;
  logic [31:0] B;
  logic        Bin;
  logic        OutValid;
  logic        OutReady;
  logic [31:0] D;
  logic        Bout;
`ifdef SUB_FLAGS_EN
  logic        Z;
  logic        N;
  logic        V;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [32:0] expQ[$];

  brent_kung_sub32_pipe dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .InValid  (InValid),
    .InReady  (InReady),
    .A        (A),
    .B        (B),
    .Bin      (Bin),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .D        (D),
    .Bout     (Bout)
`ifdef SUB_FLAGS_EN
    ,
    .Z        (Z),
    .N        (N),
    .V        (V)
`endif
  );

  always #5 Clk = ~Clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: 33-bit unsigned difference, top bit is the borrow.
  function automatic logic [32:0] subModel(input logic [31:0] a, input logic [31:0] b, input logic bin);
    logic [32:0] r;
    r = {1'b0, a} - {1'b0, b} - {32'b0, bin};
    return r;
  endfunction

  // One clock: drive at the falling edge, sample 1ns later, score the pending transfers.
  task automatic applyStimulus(input logic inV, input logic [31:0] a, input logic [31:0] b,
                               input logic bin, input logic outR, input logic [32:0] expVal,
                               output logic accepted);
    @(negedge Clk);
    InValid  = inV;
    A        = a;
    B        = b;
    Bin      = bin;
    OutReady = outR;
    #1;
    accepted = InValid & InReady;
    if (OutValid) begin
      if (expQ.size() == 0) begin
        checkOutput("spuriousOut", 64'(OutValid), 64'd0);
      end else begin
        checkOutput("result", 64'({Bout, D}), 64'(expQ[0]));
        if (OutReady) begin
          void'(expQ.pop_front());
        end
      end
    end
    if (accepted) begin
      expQ.push_back(expVal);
    end
  endtask

  task automatic sendOp(input logic [31:0] a, input logic [31:0] b, input logic bin,
                        input logic [32:0] expVal, input logic outR);
    logic acc;
    acc = 1'b0;
    for (int k = 0; k < 20 && !acc; k++) begin
      applyStimulus(1'b1, a, b, bin, outR, expVal, acc);
    end
    checkOutput("sendAccept", 64'(acc), 64'd1);
  endtask

  task automatic drain(input int budget);
    logic acc;
    for (int k = 0; k < budget && expQ.size() != 0; k++) begin
      applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 33'd0, acc);
    end
    checkOutput("drainEmpty", 64'(expQ.size()), 64'd0);
  endtask

  initial begin
    logic        acc;
    logic [31:0] ra, rb;
    logic        rbin;
    int          sent;
    int          accCnt;

    Rst      = 1'b1;
    InValid  = 1'b0;
    A        = 32'd0;
    B        = 32'd0;
    Bin      = 1'b0;
    OutReady = 1'b0;
    #1;
    checkOutput("rstOutValid", 64'(OutValid), 64'd0);
    checkOutput("rstD", 64'(D), 64'd0);
    checkOutput("rstBout", 64'(Bout), 64'd0);
    checkOutput("rstInReady", 64'(InReady), 64'd1);
    @(negedge Clk);
    @(negedge Clk);
    Rst = 1'b0;

    // Latency: 10 - 3 appears after the third edge counting the transfer edge, for one cycle.
    applyStimulus(1'b1, 32'd10, 32'd3, 1'b0, 1'b1, {1'b0, 32'd7}, acc);
    checkOutput("t1Accept", 64'(acc), 64'd1);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 33'd0, acc);
    checkOutput("t1Lat1", 64'(OutValid), 64'd0);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 33'd0, acc);
    checkOutput("t1Lat2", 64'(OutValid), 64'd0);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 33'd0, acc);
    checkOutput("t1Valid", 64'(OutValid), 64'd1);
    checkOutput("t1D", 64'(D), 64'd7);
    checkOutput("t1Bout", 64'(Bout), 64'd0);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 33'd0, acc);
    checkOutput("t1OnePulse", 64'(OutValid), 64'd0);

    // Boundary vectors, expected values worked by hand.
    sendOp(32'd0,          32'd1,          1'b0, {1'b1, 32'hFFFF_FFFF}, 1'b1);
    sendOp(32'd0,          32'd0,          1'b1, {1'b1, 32'hFFFF_FFFF}, 1'b1);
    sendOp(32'h8000_0000,  32'h8000_0000,  1'b0, {1'b0, 32'h0000_0000}, 1'b1);
    sendOp(32'hFFFF_FFFF,  32'd0,          1'b1, {1'b0, 32'hFFFF_FFFE}, 1'b1);
    sendOp(32'd5,          32'd6,          1'b1, {1'b1, 32'hFFFF_FFFE}, 1'b1);
    sendOp(32'h1234_5678,  32'h0234_5678,  1'b0, {1'b0, 32'h1000_0000}, 1'b1);
    drain(20);

    // Random back-to-back traffic with a randomly stalling consumer.
    sent = 0;
    ra   = $urandom;
    rb   = $urandom;
    rbin = 1'($urandom_range(0, 1));
    for (int k = 0; k < 2000 && sent < 100; k++) begin
      applyStimulus(1'b1, ra, rb, rbin, 1'($urandom_range(0, 1)), subModel(ra, rb, rbin), acc);
      if (acc) begin
        sent++;
        ra   = $urandom;
        rb   = $urandom;
        rbin = 1'($urandom_range(0, 1));
      end
    end
    checkOutput("randSent", 64'(sent), 64'd100);
    drain(50);

    // Consumer stalled for 6 cycles with a producer always offering: exactly 3 fit.
    accCnt = 0;
    ra     = 32'd100;
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b1, ra, 32'd1, 1'b0, 1'b0, subModel(ra, 32'd1, 1'b0), acc);
      if (acc) begin
        accCnt++;
        ra = ra + 32'd1;
      end
    end
    checkOutput("stallAccepts", 64'(accCnt), 64'd3);
    checkOutput("stallInReady", 64'(InReady), 64'd0);
    applyStimulus(1'b1, ra, 32'd1, 1'b0, 1'b1, subModel(ra, 32'd1, 1'b0), acc);
    checkOutput("resumeInReady", 64'(acc), 64'd1);
    drain(20);

    // Reset with three operations in flight: everything cleared, nothing emitted afterwards.
    sendOp(32'd50, 32'd1, 1'b0, {1'b0, 32'd49}, 1'b0);
    sendOp(32'd51, 32'd1, 1'b0, {1'b0, 32'd50}, 1'b0);
    sendOp(32'd52, 32'd1, 1'b0, {1'b0, 32'd51}, 1'b0);
    @(negedge Clk);
    Rst     = 1'b1;
    InValid = 1'b0;
    #1;
    checkOutput("midRstValid", 64'(OutValid), 64'd0);
    checkOutput("midRstD", 64'(D), 64'd0);
    checkOutput("midRstBout", 64'(Bout), 64'd0);
    checkOutput("midRstInReady", 64'(InReady), 64'd1);
    expQ.delete();
    @(negedge Clk);
    Rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 33'd0, acc);
      checkOutput("postRstValid", 64'(OutValid), 64'd0);
    end
    sendOp(32'd20, 32'd5, 1'b1, {1'b0, 32'd14}, 1'b1);
    drain(20);

`ifdef SUB_FLAGS_EN
    // Flags ride with the result and are held while the consumer stalls.
    sendOp(32'h8000_0000, 32'd1, 1'b0, {1'b0, 32'h7FFF_FFFF}, 1'b0);
    for (int k = 0; k < 20 && !OutValid; k++) begin
      applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 33'd0, acc);
    end
    checkOutput("flagWait1", 64'(OutValid), 64'd1);
    checkOutput("flagV1", 64'(V), 64'd1);
    checkOutput("flagN1", 64'(N), 64'd0);
    checkOutput("flagZ1", 64'(Z), 64'd0);
    drain(20);
    sendOp(32'd5, 32'd5, 1'b0, {1'b0, 32'd0}, 1'b0);
    for (int k = 0; k < 20 && !OutValid; k++) begin
      applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 33'd0, acc);
    end
    checkOutput("flagWait2", 64'(OutValid), 64'd1);
    checkOutput("flagZ2", 64'(Z), 64'd1);
    checkOutput("flagV2", 64'(V), 64'd0);
    checkOutput("flagN2", 64'(N), 64'd0);
    drain(20);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
